// File: rtl/pu_out_packer.sv
// pu_out_packer: packs 16-bit ALU result elements four to a 64-bit word behind a FWFT FIFO
module pu_out_packer #(
  parameter int ACC_DATA_WIDTH = 64,
  parameter int OUT_WIDTH      = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      choose_8bit,
  input  logic                      in_valid,
  input  logic [ACC_DATA_WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [3:0]                out_keep,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [OUT_WIDTH-1:0] r_asm_word;
  logic [1:0]           r_slot;
  logic [3:0]           r_asm_keep;
  logic [OUT_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [3:0]           r_mem_keep [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;
  logic [15:0]          w_elem;
  logic [OUT_WIDTH-1:0] w_word;
  logic [3:0]           w_keep;
  logic                 w_acc, w_pop, w_push, w_unused;
  assign w_elem    = choose_8bit ? {in_data[39:32], in_data[7:0]} : in_data[15:0];
  assign w_unused  = &{1'b0, in_data[ACC_DATA_WIDTH-1:40], in_data[31:16]};
  // unwritten slots are still zero in r_asm_word, so a partial word pads itself
  assign w_word    = r_asm_word | (OUT_WIDTH'(w_elem) << {r_slot, 4'b0});
  assign w_keep    = r_asm_keep | (4'b1 << r_slot);
  assign in_ready  = !reset && (r_count != (AW+1)'(FIFO_DEPTH));
  assign out_valid = r_count != '0;
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = w_acc && (r_slot == 2'd3 || in_last);
  assign out_data  = out_valid ? r_mem_data[r_rptr] : '0;
  assign out_keep  = out_valid ? r_mem_keep[r_rptr] : '0;
  assign out_last  = out_valid && r_mem_last[r_rptr];
  assign busy      = (r_slot != 2'd0) || out_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm_word <= '0;
      r_asm_keep <= '0;
      r_slot     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_acc) begin
        r_asm_word <= w_push ? '0 : w_word;
        r_asm_keep <= w_push ? '0 : w_keep;
        r_slot     <= w_push ? 2'd0 : r_slot + 2'd1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_word;
      r_mem_keep[r_wptr] <= w_keep;
      r_mem_last[r_wptr] <= in_last;
    end
  end
endmodule

// File: tb/tb_pu_out_packer.sv
// tb_pu_out_packer: directed table, corner sequences and scoreboard for pu_out_packer
module tb_pu_out_packer;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, choose_8bit = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [63:0] out_data;
  logic [3:0] out_keep;
  int n_tests = 0, n_fail = 0, n_pop = 0;

  always #5 clk = ~clk;

  pu_out_packer #(.ACC_DATA_WIDTH(64), .OUT_WIDTH(64), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .choose_8bit(choose_8bit), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_ready(out_ready), .busy(busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic c, input logic [63:0] d, input logic l);
    int t = 0;
    bit ok = 0;
    choose_8bit = c; in_data = d; in_last = l; in_valid = 1;
    while (!ok && t < 64) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      t++;
    end
    if (!ok) fail_now("send_timeout");
  endtask

  task automatic idle;
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain;
    int t = 0;
    idle();
    out_ready = 1;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 64);
    if (busy) fail_now("drain_timeout");
    tick();
  endtask

  // scoreboard: reference assembly plus queue of expected FIFO words
  typedef struct packed {logic [63:0] d; logic [3:0] k; logic l;} wrd_t;
  wrd_t q[$];
  wrd_t h;
  logic [63:0] m_word = '0;
  logic [1:0] m_slot = '0;
  logic [3:0] m_keep = '0;
  logic [15:0] m_elem;
  logic pc = 0;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_word = '0; m_slot = '0; m_keep = '0;
      chk("rst_in_ready", in_ready, 0);
    end else begin
      if (busy && choose_8bit !== pc) fail_now("mode_change_busy");
      chk("sb_in_ready", in_ready, q.size() != DEPTH);
      chk("sb_out_valid", out_valid, q.size() != 0);
      chk("sb_busy", busy, (m_slot != 0) || (q.size() != 0));
      if (!out_valid) chk("sb_idle_out", {out_data[59:0], out_keep}, {out_last, 63'd0});
      if (out_valid && out_ready && q.size() > 0) begin
        h = q.pop_front();
        chk("sb_data", out_data, h.d);
        chk("sb_keep", out_keep, h.k);
        chk("sb_last", out_last, h.l);
        n_pop++;
      end
      if (in_valid && in_ready) begin
        m_elem = choose_8bit ? {in_data[39:32], in_data[7:0]} : in_data[15:0];
        m_word[m_slot*16 +: 16] = m_elem;
        m_keep[m_slot] = 1'b1;
        if (m_slot == 2'd3 || in_last) begin
          q.push_back({m_word, m_keep, in_last});
          m_word = '0; m_slot = '0; m_keep = '0;
        end else m_slot++;
      end
    end
    pc = choose_8bit;
  end

  typedef struct {
    logic c, v, l;
    logic [63:0] d;
    logic ev;
    logic [63:0] ed;
    logic [3:0] ek;
    logic el, eb;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic c, v, l, input logic [63:0] d, input logic ev,
                              input logic [63:0] ed, input logic [3:0] ek, input logic el, eb);
    vec_t r;
    r.c = c; r.v = v; r.l = l; r.d = d; r.ev = ev; r.ed = ed; r.ek = ek; r.el = el; r.eb = eb;
    return r;
  endfunction

  task automatic rand_phase(input logic c);
    int acc = 0, cyc = 0;
    while (acc < 2500 && cyc < 20000) begin
      choose_8bit = c;
      in_valid = $urandom_range(0, 3) != 0;
      in_data = {$urandom, $urandom};
      in_last = $urandom_range(0, 7) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      tick();
      cyc++;
    end
    if (acc < 2500) fail_now("rand_beat_budget");
    send(c, {$urandom, $urandom}, 1);
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(1, 1, 0, 64'hFFFFFF01_FFFFFF02, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 64'h12345603_789ABC04, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 64'h00000005_00000006, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 64'hA5A5A507_5A5A5A08, 1, 64'h0708_0506_0304_0102, 4'hF, 1, 1));
    tbl.push_back(mk(1, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'hDEADBEEF_CAFE1111, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 64'h00000000_00002222, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 64'hFFFFFFFF_FFFF3333, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 64'h12345678_9ABC4444, 1, 64'h4444_3333_2222_1111, 4'hF, 0, 1));
    tbl.push_back(mk(0, 1, 1, 64'h00000000_00005555, 1, 64'h0000_0000_0000_5555, 4'h1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h00000000_0000AAAA, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 64'h0000FFFF_0000BBBB, 1, 64'h0000_0000_BBBB_AAAA, 4'h3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 64'h00000080_0000007F, 1, 64'h0000_0000_0000_807F, 4'h1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 64'h0, 0, 0, 0, 0, 0));

    repeat (3) tick();
    chk("reset_in_ready", in_ready, 0);
    reset = 0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_out_data", out_data, 0);
    chk("post_reset_out_keep", out_keep, 0);
    chk("post_reset_out_last", out_last, 0);
    chk("post_reset_busy", busy, 0);
    tick();

    out_ready = 1;
    foreach (tbl[i]) begin
      choose_8bit = tbl[i].c; in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l;
      tick();
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_out_keep", i), out_keep, tbl[i].ek);
      chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].el);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
    end
    idle();

    // backpressure: four words fill the FIFO, then ready releases them in order
    out_ready = 0;
    for (int i = 0; i < 16; i++) send(0, {32'hCAFEF00D, 16'hBEEF, 16'(i)}, 0);
    in_data = {32'hCAFEF00D, 16'hBEEF, 16'd16};
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, 64'h0003_0002_0001_0000);
    chk("bp_head_keep", out_keep, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, 64'h0003_0002_0001_0000);
    end
    n_pop = 0;
    out_ready = 1;
    fork
      begin
        for (int i = 16; i < 20; i++) send(0, {32'hCAFEF00D, 16'hBEEF, 16'(i)}, 0);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        chk("bp_drain_rate", n_pop, 4);
      end
    join
    drain();
    chk("bp_total_words", n_pop, 5);

    // hold count at FIFO_DEPTH-1 with a pop on every push, three pointer laps
    out_ready = 0;
    for (int i = 0; i < 12; i++) send(0, {$urandom, $urandom}, 0);
    for (int i = 0; i < 48; i++) begin
      choose_8bit = 0; in_valid = 1; in_last = 0; in_data = {$urandom, $urandom};
      out_ready = (i % 4) == 3;
      @(negedge clk);
      chk("spp_in_ready", in_ready, 1);
      chk("spp_out_valid", out_valid, 1);
      chk("spp_count", q.size(), 3);
      tick();
    end
    drain();

    // reset mid-word with a full word already queued
    out_ready = 0;
    for (int i = 0; i < 6; i++) send(0, 64'h100 + 64'(i), 0);
    idle();
    reset = 1;
    tick();
    chk("rm_in_ready", in_ready, 0);
    reset = 0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_in_ready_after", in_ready, 1);
    n_pop = 0;
    for (int i = 0; i < 4; i++) send(0, 64'h200 + 64'(i), 0);
    idle();
    chk("rm_word_valid", out_valid, 1);
    chk("rm_word_data", out_data, 64'h0203_0202_0201_0200);
    chk("rm_word_keep", out_keep, 4'hF);
    chk("rm_word_last", out_last, 0);
    drain();
    chk("rm_word_count", n_pop, 1);

    rand_phase(0);
    rand_phase(1);
    rand_phase(0);
    rand_phase(1);
    chk("final_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
